// File: rtl/rally_referee.sv
// rally_referee: watches the ball stage, decides when a rally has ended,
// awards the point to the correct player, keeps tennis-style point and game
// scores and drives the serve command back into the ball stage.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   start               1-cycle pulse, begins a match from IDLE or MATCH_OVER
//   light[15:0]         one-hot ball position, 0 = no ball on court
//   direction[1:0]      01 moving left, 10 moving right, 00 idle
//   serve[1:0]          1-cycle serve command, 01 left serves, 10 right serves
//   left/right_points   0=0, 1=15, 2=30, 3=40, 4=ADV
//   left/right_games    games won by each player
//   point_won[1:0]      1-cycle pulse, 01 left won, 10 right won
//   winner[1:0]         match winner, held until reset or start
//   busy                high except in IDLE and MATCH_OVER
// All outputs are registered.
module rally_referee #(
  parameter int MISS_CYCLES   = 4,
  parameter int GAP_CYCLES    = 8,
  parameter int SERVE_TIMEOUT = 64,
  parameter int GAMES_TO_WIN  = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] light,
  input  logic [1:0]  direction,
  output logic [1:0]  serve,
  output logic [2:0]  left_points,
  output logic [2:0]  right_points,
  output logic [3:0]  left_games,
  output logic [3:0]  right_games,
  output logic [1:0]  point_won,
  output logic [1:0]  winner,
  output logic        busy
);

  localparam int WAIT_W = (SERVE_TIMEOUT > 1) ? $clog2(SERVE_TIMEOUT) : 1;
  localparam int MISS_W = (MISS_CYCLES > 1) ? $clog2(MISS_CYCLES) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SERVE_TIMEOUT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]        GAMES_MAX = 4'(GAMES_TO_WIN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVE,
    S_WAIT_BALL,
    S_RALLY,
    S_POINT,
    S_GAP,
    S_MATCH_OVER
  } state_e;

  state_e             state_q, state_d;
  logic               server_q, server_d;    // 0 = left, 1 = right
  logic [1:0]         last_dir_q, last_dir_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [2:0]         lp_q, lp_d, rp_q, rp_d;
  logic [3:0]         lg_q, lg_d, rg_q, rg_d;
  logic [1:0]         winner_q, winner_d;
  logic [1:0]         serve_q, serve_d;
  logic [1:0]         point_won_q, point_won_d;
  logic               busy_q, busy_d;

  // Games counter never runs past the match-winning count.
  function automatic logic [3:0] games_inc(input logic [3:0] g);
    return (g < GAMES_MAX) ? g + 4'd1 : g;
  endfunction

  // Point award decode, evaluated from the direction the ball last travelled.
  // A ball that left moving left got past the left player, so right scores.
  logic       right_wins, award, game, match_won;
  logic [2:0] w_pts, l_pts, w_pts_n, l_pts_n;
  logic [3:0] w_games, w_games_n;

  always_comb begin
    right_wins = (last_dir_q == 2'b01);
    award      = (last_dir_q == 2'b01) || (last_dir_q == 2'b10);
    w_pts      = right_wins ? rp_q : lp_q;
    l_pts      = right_wins ? lp_q : rp_q;
    w_games    = right_wins ? rg_q : lg_q;
    w_pts_n    = w_pts;
    l_pts_n    = l_pts;
    game       = 1'b0;
    if (w_pts < 3'd3) begin
      w_pts_n = w_pts + 3'd1;
    end else if (w_pts == 3'd3) begin
      if (l_pts < 3'd3)       game    = 1'b1;
      else if (l_pts == 3'd3) w_pts_n = 3'd4;   // advantage
      else                    l_pts_n = 3'd3;   // back to deuce
    end else begin
      game = 1'b1;
    end
    if (game) begin
      w_pts_n = 3'd0;
      l_pts_n = 3'd0;
    end
    w_games_n = game ? games_inc(w_games) : w_games;
    match_won = award && game && (w_games_n == GAMES_MAX);
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      server_q    <= 1'b0;
      last_dir_q  <= 2'b00;
      wait_q      <= '0;
      miss_q      <= '0;
      gap_q       <= '0;
      lp_q        <= '0;
      rp_q        <= '0;
      lg_q        <= '0;
      rg_q        <= '0;
      winner_q    <= 2'b00;
      serve_q     <= 2'b00;
      point_won_q <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      server_q    <= server_d;
      last_dir_q  <= last_dir_d;
      wait_q      <= wait_d;
      miss_q      <= miss_d;
      gap_q       <= gap_d;
      lp_q        <= lp_d;
      rp_q        <= rp_d;
      lg_q        <= lg_d;
      rg_q        <= rg_d;
      winner_q    <= winner_d;
      serve_q     <= serve_d;
      point_won_q <= point_won_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:       if (start) state_d = S_SERVE;
      S_SERVE:      state_d = S_WAIT_BALL;
      S_WAIT_BALL: begin
        if (light != 16'h0000)     state_d = S_RALLY;
        else if (wait_q == WAIT_LAST) state_d = S_SERVE;
      end
      S_RALLY:      if ((light == 16'h0000) && (miss_q == MISS_LAST)) state_d = S_POINT;
      S_POINT:      state_d = match_won ? S_MATCH_OVER : S_GAP;
      S_GAP:        if (gap_q == GAP_LAST) state_d = S_SERVE;
      S_MATCH_OVER: if (start) state_d = S_SERVE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    server_d    = server_q;
    last_dir_d  = last_dir_q;
    wait_d      = wait_q;
    miss_d      = miss_q;
    gap_d       = gap_q;
    lp_d        = lp_q;
    rp_d        = rp_q;
    lg_d        = lg_q;
    rg_d        = rg_q;
    winner_d    = winner_q;
    point_won_d = 2'b00;
    unique case (state_q)
      S_IDLE, S_MATCH_OVER: begin
        if (start) begin
          server_d = 1'b0;
          lp_d     = '0;
          rp_d     = '0;
          lg_d     = '0;
          rg_d     = '0;
          winner_d = 2'b00;
        end
      end
      S_SERVE: wait_d = '0;
      S_WAIT_BALL: begin
        // Capture the direction already on the cycle the ball appears.
        if (light != 16'h0000) begin
          miss_d = '0;
          if (direction != 2'b00) last_dir_d = direction;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_RALLY: begin
        if (direction != 2'b00) last_dir_d = direction;
        if (light != 16'h0000)      miss_d = '0;
        else if (miss_q == MISS_LAST) miss_d = '0;
        else                          miss_d = miss_q + 1'b1;
      end
      S_POINT: begin
        gap_d      = '0;
        last_dir_d = 2'b00;
        if (award) begin
          point_won_d = right_wins ? 2'b10 : 2'b01;
          if (right_wins) begin
            rp_d = w_pts_n;
            lp_d = l_pts_n;
            rg_d = w_games_n;
          end else begin
            lp_d = w_pts_n;
            rp_d = l_pts_n;
            lg_d = w_games_n;
          end
          if (game)      server_d = ~server_q;
          if (match_won) winner_d = right_wins ? 2'b10 : 2'b01;
        end
      end
      S_GAP:   gap_d = gap_q + 1'b1;
      default: ;
    endcase
    // Serve and busy are decoded from the state being entered so that they
    // line up with the state itself once registered.
    serve_d = (state_d == S_SERVE) ? (server_d ? 2'b10 : 2'b01) : 2'b00;
    busy_d  = (state_d != S_IDLE) && (state_d != S_MATCH_OVER);
  end

  assign serve        = serve_q;
  assign left_points  = lp_q;
  assign right_points = rp_q;
  assign left_games   = lg_q;
  assign right_games  = rg_q;
  assign point_won    = point_won_q;
  assign winner       = winner_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_rally_referee.sv
// Directed testbench for rally_referee: serve timing, re-serve timeout,
// miss detection and cancellation, deuce/advantage scoring, game and match
// completion, restart, and reset in mid-rally.
module tb_rally_referee;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] light;
  logic [1:0]  direction;
  logic [1:0]  serve;
  logic [2:0]  left_points, right_points;
  logic [3:0]  left_games, right_games;
  logic [1:0]  point_won, winner;
  logic        busy;

  rally_referee dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .light        (light),
    .direction    (direction),
    .serve        (serve),
    .left_points  (left_points),
    .right_points (right_points),
    .left_games   (left_games),
    .right_games  (right_games),
    .point_won    (point_won),
    .winner       (winner),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  int pw_pulses   = 0;
  int serve_cyc   = 0;
  int overlap     = 0;

  always @(negedge clock) begin
    if (point_won != 2'b00) pw_pulses <= pw_pulses + 1;
    if (serve != 2'b00)     serve_cyc <= serve_cyc + 1;
    if (serve != 2'b00 && point_won != 2'b00) overlap <= overlap + 1;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ticks until a serve pulse is visible, bounded.
  task automatic wait_serve(output int n);
    n = 0;
    do begin
      tick;
      n++;
    end while (serve == 2'b00 && n < 200);
  endtask

  // Plays one rally starting from a visible serve: ball on court for three
  // cycles, then four empty cycles ending the rally.
  task automatic play(input logic [1:0] dir, input logic [1:0] exp_pw,
                      input bit exp_serve, input string tag);
    int n;
    light = 16'h0001;
    direction = dir;
    repeat (3) tick;
    light = 16'h0000;
    repeat (4) tick;
    chk({tag, "_pw_early"}, 16'(point_won), 16'h0);
    tick;
    chk({tag, "_pw"}, 16'(point_won), 16'(exp_pw));
    if (exp_serve) begin
      wait_serve(n);
      chk({tag, "_gap"}, 16'(n), 16'd8);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_serve"}, 16'(serve), 16'h0);
    chk({tag, "_lp"}, 16'(left_points), 16'h0);
    chk({tag, "_rp"}, 16'(right_points), 16'h0);
    chk({tag, "_lg"}, 16'(left_games), 16'h0);
    chk({tag, "_rg"}, 16'(right_games), 16'h0);
    chk({tag, "_pw"}, 16'(point_won), 16'h0);
    chk({tag, "_winner"}, 16'(winner), 16'h0);
    chk({tag, "_busy"}, 16'(busy), 16'h0);
  endtask

  initial begin
    int n;
    int pw0;
    int s0;
    reset = 1'b1;
    start = 1'b0;
    light = 16'h0000;
    direction = 2'b00;
    repeat (2) tick;
    chk_all_zero("reset");
    reset = 1'b0;
    tick;

    // Start: serve one cycle later, then re-serve after the timeout
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("t1_serve", 16'(serve), 16'h1);
    chk("t1_busy", 16'(busy), 16'h1);
    pw0 = pw_pulses;
    wait_serve(n);
    chk("t1_reserve_delay", 16'(n), 16'd65);
    chk("t1_reserve", 16'(serve), 16'h1);
    chk("t1_no_pw", 16'(pw_pulses - pw0), 16'h0);
    tick;
    chk("t1_serve_pulse", 16'(serve), 16'h0);
    s0 = serve_cyc;
    wait_serve(n);
    chk("t1_reserve2_delay", 16'(n), 16'd64);

    // Ball passes the left player: right wins
    play(2'b01, 2'b10, 1'b1, "t2");
    chk("t2_rp", 16'(right_points), 16'd1);
    chk("t2_lp", 16'(left_points), 16'd0);
    chk("t2_serve", 16'(serve), 16'h1);

    // Three empty cycles then the ball reappears: no point yet
    light = 16'h0001;
    direction = 2'b10;
    repeat (3) tick;
    light = 16'h0000;
    repeat (3) tick;
    pw0 = pw_pulses;
    light = 16'h0100;
    tick;
    light = 16'h0000;
    repeat (4) tick;
    chk("t3_cancel_pw", 16'(point_won), 16'h0);
    chk("t3_cancel_cnt", 16'(pw_pulses - pw0), 16'h0);
    tick;
    chk("t3_pw", 16'(point_won), 16'h1);
    wait_serve(n);
    chk("t3_gap", 16'(n), 16'd8);
    chk("t3_lp", 16'(left_points), 16'd1);
    chk("t3_rp", 16'(right_points), 16'd1);

    // Deuce / advantage sequence and a left game
    play(2'b10, 2'b01, 1'b1, "t4a");
    play(2'b10, 2'b01, 1'b1, "t4b");
    chk("t4_lp3", 16'(left_points), 16'd3);
    play(2'b01, 2'b10, 1'b1, "t4c");
    play(2'b01, 2'b10, 1'b1, "t4d");
    chk("t4_rp3", 16'(right_points), 16'd3);
    play(2'b01, 2'b10, 1'b1, "t4e");
    chk("t4_rp_adv", 16'(right_points), 16'd4);
    chk("t4_lp_adv", 16'(left_points), 16'd3);
    play(2'b10, 2'b01, 1'b1, "t4f");
    chk("t4_rp_deuce", 16'(right_points), 16'd3);
    chk("t4_lp_deuce", 16'(left_points), 16'd3);
    play(2'b10, 2'b01, 1'b1, "t4g");
    chk("t4_lp_adv2", 16'(left_points), 16'd4);
    play(2'b10, 2'b01, 1'b1, "t4h");
    chk("t4_lg", 16'(left_games), 16'd1);
    chk("t4_rg", 16'(right_games), 16'd0);
    chk("t4_lp0", 16'(left_points), 16'd0);
    chk("t4_rp0", 16'(right_points), 16'd0);
    chk("t4_serve_right", 16'(serve), 16'h2);

    // Reset in mid-rally after two empty cycles
    light = 16'h0001;
    direction = 2'b10;
    repeat (3) tick;
    light = 16'h0000;
    repeat (2) tick;
    pw0 = pw_pulses;
    reset = 1'b1;
    tick;
    chk_all_zero("t6");
    reset = 1'b0;
    repeat (4) tick;
    chk("t6_no_pw", 16'(pw_pulses - pw0), 16'h0);
    chk("t6_idle_busy", 16'(busy), 16'h0);
    chk("t6_idle_serve", 16'(serve), 16'h0);

    // Full match: left wins 24 straight points
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("t5_serve", 16'(serve), 16'h1);
    for (int i = 0; i < 24; i++) begin
      play(2'b10, 2'b01, (i != 23), $sformatf("t5_%0d", i));
    end
    chk("t5_lg", 16'(left_games), 16'd6);
    chk("t5_rg", 16'(right_games), 16'd0);
    chk("t5_winner", 16'(winner), 16'h1);
    chk("t5_busy", 16'(busy), 16'h0);
    chk("t5_lp", 16'(left_points), 16'd0);
    s0 = serve_cyc;
    repeat (20) tick;
    chk("t5_no_serve", 16'(serve_cyc - s0), 16'h0);
    chk("t5_winner_held", 16'(winner), 16'h1);
    chk("t5_games_held", 16'(left_games), 16'd6);

    // Restart from MATCH_OVER
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("t7_serve", 16'(serve), 16'h1);
    chk("t7_lg", 16'(left_games), 16'd0);
    chk("t7_winner", 16'(winner), 16'h0);
    chk("t7_busy", 16'(busy), 16'h1);
    chk("t7_lp", 16'(left_points), 16'd0);
    tick;
    chk("overlap", 16'(overlap), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
